// File: rtl/btb_pkg.sv
// Shared types for the set-associative branch target buffer: entry layout,
// 2-bit direction counter encoding, flush sequencer states and counter update.
package btb_pkg;

    localparam int BTB_XLEN     = 32;
    localparam int BTB_NUM_SETS = 8;
    localparam int BTB_TAG_W    = BTB_XLEN - $clog2(BTB_NUM_SETS) - 2;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } btb_fsm_e;

    localparam btb_fsm_e FSM_ALLOC = WEAK_T;

    typedef enum logic {
        FL_IDLE  = 1'b0,
        FL_FLUSH = 1'b1
    } flush_state_e;

    // Entry layout for the default geometry; the top builds the same layout
    // at its own widths and hands it to the matcher as a type parameter.
    typedef struct packed {
        logic                  valid;
        logic [BTB_TAG_W-1:0]  tag;
        logic [BTB_XLEN-1:0]   target;
        btb_fsm_e              fsm;
    } btb_entry_t;

    function automatic btb_fsm_e fsm_next(input btb_fsm_e cur, input logic taken);
        logic [1:0] val;
        val = cur;
        if (taken && (cur != STRONG_T)) begin
            val = val + 2'd1;
        end else if (!taken && (cur != STRONG_NT)) begin
            val = val - 2'd1;
        end
        return btb_fsm_e'(val);
    endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup, execute-side update and flush control of btb_assoc.
// Lookup: lookup_valid qualifies lookup_pc for one cycle; there is no ready,
// the BTB accepts every cycle and answers on pred_* one cycle later.
interface btb_assoc_if #(parameter int XLEN = 32);
    import btb_pkg::*;

    logic            lookup_valid;
    logic [XLEN-1:0] lookup_pc;
    logic            pred_valid;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [1:0]      pred_fsm;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            flush_req;
    logic            flush_busy;
    flush_state_e    flush_state;

    modport master (
        output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush_req,
        input  pred_valid, pred_hit, pred_taken, pred_target, pred_fsm, flush_busy, flush_state
    );

    modport slave (
        input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush_req,
        output pred_valid, pred_hit, pred_taken, pred_target, pred_fsm, flush_busy, flush_state
    );

endinterface

// File: rtl/btb_way_match.sv
// Combinational tag compare across the ways of one set; the lowest-index
// matching valid way wins. Miss returns target 0 and counter STRONG_NT.
module btb_way_match
    import btb_pkg::*;
#(
    parameter int  NUM_WAYS = 2,
    parameter int  TAG_W    = BTB_TAG_W,
    parameter int  XLEN     = BTB_XLEN,
    parameter int  WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    parameter type entry_t  = btb_entry_t
) (
    input  entry_t           set_in [NUM_WAYS],
    input  logic [TAG_W-1:0] tag,
    output logic             hit,
    output logic [WAY_W-1:0] way,
    output logic [XLEN-1:0]  target,
    output btb_fsm_e         fsm
);

    always_comb begin
        hit    = 1'b0;
        way    = '0;
        target = '0;
        fsm    = STRONG_NT;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (set_in[w].valid && (set_in[w].tag == tag)) begin
                hit    = 1'b1;
                way    = WAY_W'(w);
                target = set_in[w].target;
                fsm    = set_in[w].fsm;
            end
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: registered lookup, in-place update with round-robin
// eviction and a one-set-per-cycle flush. Option macro: BTB_BYPASS_EN.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int NUM_WAYS = 2,
    parameter int XLEN     = 32
) (
    input logic        clk,
    input logic        rst_n,
    btb_assoc_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        btb_fsm_e         fsm;
    } entry_t;

    entry_t           mem [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0] rr  [NUM_SETS];

    flush_state_e     state_q, state_d;
    logic [IDX_W-1:0] flush_set;
    logic             busy;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    entry_t           l_set [NUM_WAYS];
    entry_t           u_set [NUM_WAYS];

    logic             l_hit, u_hit;
    logic [WAY_W-1:0] lk_way_unused, u_way;
    logic [XLEN-1:0]  l_tgt, u_tgt_unused;
    btb_fsm_e         l_fsm, u_fsm_unused;

    logic             inv_found;
    logic [WAY_W-1:0] inv_way, write_way, rr_next;
    logic             write_en, rr_adv, lk_ok;
    entry_t           new_entry;
    logic             unused_bits;

    assign busy        = (state_q == FL_FLUSH);
    assign l_idx       = bus.lookup_pc[IDX_W+1:2];
    assign l_tag       = bus.lookup_pc[XLEN-1:IDX_W+2];
    assign u_idx       = bus.upd_pc[IDX_W+1:2];
    assign u_tag       = bus.upd_pc[XLEN-1:IDX_W+2];
    assign lk_ok       = bus.lookup_valid && !busy;
    assign unused_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            FL_IDLE:  if (bus.flush_req) state_d = FL_FLUSH;
            FL_FLUSH: if (flush_set == IDX_W'(NUM_SETS - 1)) state_d = FL_IDLE;
            default:  state_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FL_IDLE;
            flush_set <= '0;
        end else begin
            state_q   <= state_d;
            flush_set <= busy ? flush_set + 1'b1 : '0;
        end
    end

    assign bus.flush_busy  = busy;
    assign bus.flush_state = state_q;

    always_comb begin
        u_set = mem[u_idx];
    end

    btb_way_match #(
        .NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W), .XLEN(XLEN), .WAY_W(WAY_W), .entry_t(entry_t)
    ) u_upd_match (
        .set_in(u_set), .tag(u_tag), .hit(u_hit), .way(u_way),
        .target(u_tgt_unused), .fsm(u_fsm_unused)
    );

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!u_set[w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign rr_next = (rr[u_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr[u_idx] + 1'b1;

    // Hits train in place; taken misses allocate, evicting round-robin only when the set is full.
    always_comb begin
        write_en  = 1'b0;
        rr_adv    = 1'b0;
        write_way = u_way;
        new_entry = u_set[u_way];
        if (bus.upd_valid && !busy) begin
            if (u_hit) begin
                write_en      = 1'b1;
                new_entry.fsm = fsm_next(u_set[u_way].fsm, bus.upd_taken);
                if (bus.upd_taken) new_entry.target = bus.upd_target;
            end else if (bus.upd_taken) begin
                write_en  = 1'b1;
                new_entry = '{valid: 1'b1, tag: u_tag, target: bus.upd_target, fsm: FSM_ALLOC};
                if (inv_found) begin
                    write_way = inv_way;
                end else begin
                    write_way = rr[u_idx];
                    rr_adv    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                rr[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) mem[s][w] <= '0;
            end
        end else if (busy) begin
            rr[flush_set] <= '0;
            for (int w = 0; w < NUM_WAYS; w++) mem[flush_set][w].valid <= 1'b0;
        end else if (write_en) begin
            mem[u_idx][write_way] <= new_entry;
            if (rr_adv) rr[u_idx] <= rr_next;
        end
    end

    always_comb begin
        l_set = mem[l_idx];
`ifdef BTB_BYPASS_EN
        if (write_en && (u_idx == l_idx)) l_set[write_way] = new_entry;
`endif
    end

    btb_way_match #(
        .NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W), .XLEN(XLEN), .WAY_W(WAY_W), .entry_t(entry_t)
    ) u_lookup_match (
        .set_in(l_set), .tag(l_tag), .hit(l_hit), .way(lk_way_unused),
        .target(l_tgt), .fsm(l_fsm)
    );

    // Every pred_* field reads as zero whenever pred_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pred_valid  <= 1'b0;
            bus.pred_hit    <= 1'b0;
            bus.pred_taken  <= 1'b0;
            bus.pred_target <= '0;
            bus.pred_fsm    <= 2'b00;
        end else begin
            bus.pred_valid  <= lk_ok;
            bus.pred_hit    <= lk_ok && l_hit;
            bus.pred_taken  <= lk_ok && l_hit && l_fsm[1];
            bus.pred_target <= (lk_ok && l_hit) ? l_tgt : '0;
            bus.pred_fsm    <= (lk_ok && l_hit) ? l_fsm : 2'b00;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed vector table, hand-written
// flush/conflict/reset sequences and random traffic against a set/way model.
module tb_btb_assoc;
    import btb_pkg::*;

    localparam int NS = 8;
    localparam int NW = 2;
    localparam int XL = 32;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btb_assoc_if #(.XLEN(XL)) bus ();

    btb_assoc #(.NUM_SETS(NS), .NUM_WAYS(NW), .XLEN(XL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: plain per-set way arrays following the allocation rules.
    bit          m_val [NS][NW];
    logic [31:0] m_tag [NS][NW];
    logic [31:0] m_tgt [NS][NW];
    int          m_fsm [NS][NW];
    int          m_rr  [NS];
    int          m_busy;

    logic        e_valid, e_hit, e_taken, e_busy;
    logic [31:0] e_tgt;
    logic [1:0]  e_fsm;
    logic        a_valid, a_hit, a_taken, a_busy;
    logic [31:0] a_tgt;
    logic [1:0]  a_fsm;

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        ev;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
        logic [1:0]  efsm;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) m_val[s][w] = 1'b0;
        end
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic hit,
                                output logic [31:0] tgt, output logic [1:0] fsm);
        int s;
        logic [31:0] tag;
        s = int'((pc >> 2) % NS);
        tag = pc >> (2 + IW);
        hit = 1'b0; tgt = '0; fsm = 2'b00;
        for (int w = 0; w < NW; w++) begin
            if (!hit && m_val[s][w] && m_tag[s][w] == tag) begin
                hit = 1'b1; tgt = m_tgt[s][w]; fsm = 2'(m_fsm[s][w]);
            end
        end
    endtask

    task automatic model_update(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        int s, hw, v;
        logic [31:0] tag;
        s = int'((pc >> 2) % NS);
        tag = pc >> (2 + IW);
        hw = -1;
        for (int w = 0; w < NW; w++)
            if (hw < 0 && m_val[s][w] && m_tag[s][w] == tag) hw = w;
        if (hw >= 0) begin
            if (t) begin
                m_fsm[s][hw] = (m_fsm[s][hw] < 3) ? m_fsm[s][hw] + 1 : 3;
                m_tgt[s][hw] = tg;
            end else begin
                m_fsm[s][hw] = (m_fsm[s][hw] > 0) ? m_fsm[s][hw] - 1 : 0;
            end
        end else if (t) begin
            v = -1;
            for (int w = 0; w < NW; w++) if (v < 0 && !m_val[s][w]) v = w;
            if (v < 0) begin
                v = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % NW;
            end
            m_val[s][v] = 1'b1; m_tag[s][v] = tag; m_tgt[s][v] = tg; m_fsm[s][v] = 2;
        end
    endtask

    task automatic set_idle();
        bus.lookup_valid = 1'b0; bus.lookup_pc = '0;
        bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;
        bus.flush_req = 1'b0;
    endtask

    task automatic capture();
        a_valid = bus.pred_valid; a_hit = bus.pred_hit; a_taken = bus.pred_taken;
        a_tgt = bus.pred_target; a_fsm = bus.pred_fsm; a_busy = bus.flush_busy;
    endtask

    // One clock: drive, predict from the model, advance, sample #1 after the edge.
    task automatic step(input logic lv, input logic [31:0] lpc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                        input logic fr);
        logic busy_now;
        busy_now = (m_busy > 0);
        bus.lookup_valid = lv; bus.lookup_pc = lpc;
        bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_taken = ut; bus.upd_target = utg;
        bus.flush_req = fr;
`ifdef BTB_BYPASS_EN
        if (!busy_now && uv) model_update(upc, ut, utg);
`endif
        e_valid = lv && !busy_now;
        e_hit = 1'b0; e_tgt = '0; e_fsm = 2'b00;
        if (e_valid) model_lookup(lpc, e_hit, e_tgt, e_fsm);
        e_taken = e_hit && e_fsm[1];
`ifndef BTB_BYPASS_EN
        if (!busy_now && uv) model_update(upc, ut, utg);
`endif
        if (busy_now) m_busy--;
        else if (fr) begin
            model_clear();
            m_busy = NS;
        end
        e_busy = (m_busy > 0);
        @(posedge clk);
        #1;
        capture();
    endtask

    task automatic check_model();
        check("pred_valid", 32'(a_valid), 32'(e_valid));
        check("pred_hit", 32'(a_hit), 32'(e_hit));
        check("pred_taken", 32'(a_taken), 32'(e_taken));
        check("pred_target", a_tgt, e_tgt);
        check("pred_fsm", 32'(a_fsm), 32'(e_fsm));
        check("flush_busy", 32'(a_busy), 32'(e_busy));
    endtask

    task automatic check_reset_outputs(input string tag);
        capture();
        check({tag, "_valid"}, 32'(a_valid), 32'd0);
        check({tag, "_hit"}, 32'(a_hit), 32'd0);
        check({tag, "_taken"}, 32'(a_taken), 32'd0);
        check({tag, "_target"}, a_tgt, 32'd0);
        check({tag, "_fsm"}, 32'(a_fsm), 32'd0);
        check({tag, "_busy"}, 32'(a_busy), 32'd0);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        model_clear();
        m_busy = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic lv, input logic [31:0] lpc, input logic uv,
                           input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                           input logic ev, input logic eh, input logic et,
                           input logic [31:0] etgt, input logic [1:0] efsm);
        vec_t v;
        v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
        v.ev = ev; v.eh = eh; v.et = et; v.etgt = etgt; v.efsm = efsm;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h1000 + (32'($urandom_range(0, 4)) << 5) + (32'($urandom_range(0, 7)) << 2);
    endfunction

    initial begin
        set_idle();
        m_busy = 0;
        model_clear();

        // lookup fields | update fields | expected pred valid/hit/taken/target/fsm
        add_vec(1, 32'h1000, 0, 0,        0, 0,        1, 0, 0, 32'h0,    2'b00);
        add_vec(0, 0,        1, 32'h1000, 1, 32'h2000, 0, 0, 0, 32'h0,    2'b00);
        add_vec(1, 32'h1000, 0, 0,        0, 0,        1, 1, 1, 32'h2000, 2'b10);
        add_vec(0, 0,        1, 32'h1000, 0, 32'h7777, 0, 0, 0, 32'h0,    2'b00);
        add_vec(0, 0,        1, 32'h1000, 0, 32'h7777, 0, 0, 0, 32'h0,    2'b00);
        add_vec(1, 32'h1000, 0, 0,        0, 0,        1, 1, 0, 32'h2000, 2'b00);
        add_vec(0, 0,        1, 32'h1000, 0, 32'h7777, 0, 0, 0, 32'h0,    2'b00);
        add_vec(1, 32'h1000, 0, 0,        0, 0,        1, 1, 0, 32'h2000, 2'b00);
        add_vec(0, 0,        1, 32'h1000, 1, 32'h2400, 0, 0, 0, 32'h0,    2'b00);
        add_vec(1, 32'h1000, 0, 0,        0, 0,        1, 1, 0, 32'h2400, 2'b01);
        add_vec(0, 0,        1, 32'h1020, 1, 32'h3020, 0, 0, 0, 32'h0,    2'b00);
        add_vec(0, 0,        1, 32'h1040, 1, 32'h3040, 0, 0, 0, 32'h0,    2'b00);
        add_vec(1, 32'h1000, 0, 0,        0, 0,        1, 0, 0, 32'h0,    2'b00);
        add_vec(1, 32'h1040, 0, 0,        0, 0,        1, 1, 1, 32'h3040, 2'b10);
        add_vec(1, 32'h1020, 1, 32'h1060, 1, 32'h3060, 1, 1, 1, 32'h3020, 2'b10);
        add_vec(1, 32'h1020, 0, 0,        0, 0,        1, 0, 0, 32'h0,    2'b00);
        add_vec(1, 32'h1060, 0, 0,        0, 0,        1, 1, 1, 32'h3060, 2'b10);
        add_vec(1, 32'h1040, 0, 0,        0, 0,        1, 1, 1, 32'h3040, 2'b10);
        add_vec(0, 0,        1, 32'h3000, 0, 32'h4000, 0, 0, 0, 32'h0,    2'b00);
        add_vec(1, 32'h3000, 0, 0,        0, 0,        1, 0, 0, 32'h0,    2'b00);
        add_vec(0, 0,        1, 32'h1004, 1, 32'h5004, 0, 0, 0, 32'h0,    2'b00);
        add_vec(1, 32'h1004, 0, 0,        0, 0,        1, 1, 1, 32'h5004, 2'b10);

        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utg, 1'b0);
            check($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d_hit", i), 32'(a_hit), 32'(vecs[i].eh));
            check($sformatf("vec%0d_taken", i), 32'(a_taken), 32'(vecs[i].et));
            check($sformatf("vec%0d_target", i), a_tgt, vecs[i].etgt);
            check($sformatf("vec%0d_fsm", i), 32'(a_fsm), 32'(vecs[i].efsm));
            check($sformatf("vec%0d_busy", i), 32'(a_busy), 32'd0);
        end

        // Flush: fill four sets, pulse flush, hammer it with updates/lookups/re-requests.
        for (int s = 0; s < 4; s++)
            step(1'b0, '0, 1'b1, 32'h1000 + 32'(s << 2), 1'b1, 32'h8000 + 32'(s), 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        check("flush_busy_rise", 32'(a_busy), 32'd1);
        for (int i = 0; i < NS; i++) begin
            step(1'b1, 32'h1000 + 32'((i % 4) << 2), 1'b1, 32'h1100 + 32'(i << 2), 1'b1,
                 32'h9000, (i == 2));
            check("flush_pred_valid", 32'(a_valid), 32'd0);
            check("flush_busy_hold", 32'(a_busy), 32'(i < NS - 1));
            check_model();
        end
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 32'h1000 + 32'(s << 2), 1'b0, '0, 1'b0, '0, 1'b0);
            check("post_flush_valid", 32'(a_valid), 32'd1);
            check("post_flush_hit", 32'(a_hit), 32'd0);
            step(1'b1, 32'h1100 + 32'(s << 2), 1'b0, '0, 1'b0, '0, 1'b0);
            check("dropped_upd_hit", 32'(a_hit), 32'd0);
            check_model();
        end

        // Same-cycle lookup and allocate on one set.
        do_reset();
        step(1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0);
`ifdef BTB_BYPASS_EN
        check("conflict_hit", 32'(a_hit), 32'd1);
        check("conflict_target", a_tgt, 32'h2000);
`else
        check("conflict_hit", 32'(a_hit), 32'd0);
        check("conflict_target", a_tgt, 32'h0);
`endif
        check_model();
        step(1'b1, 32'h1000, 1'b0, '0, 1'b0, '0, 1'b0);
        check("after_conflict_hit", 32'(a_hit), 32'd1);
        check("after_conflict_target", a_tgt, 32'h2000);

        // Reset asserted mid-flush aborts it and leaves everything invalid.
        for (int s = 0; s < 4; s++)
            step(1'b0, '0, 1'b1, 32'h1200 + 32'(s << 2), 1'b1, 32'hA000, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        repeat (3) step(1'b1, 32'h1200, 1'b0, '0, 1'b0, '0, 1'b0);
        check("midflush_busy", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("async_reset");
        model_clear();
        m_busy = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 32'h1200 + 32'(s << 2), 1'b0, '0, 1'b0, '0, 1'b0);
            check("after_abort_hit", 32'(a_hit), 32'd0);
            check_model();
        end

        // Random traffic over a small PC pool so hits, evictions and flushes all occur.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_pc(),
                 1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 2) != 0),
                 {$urandom_range(0, 32'hFFFF), 2'b00} + 32'h1_0000,
                 1'($urandom_range(0, 59) == 0));
            check_model();
        end

        set_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
